prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: memory address width; each section holds at most 2^ADDR_W-1 bytes.
REQ-002 SHALL have parameter CNT_W, default 16: width of the run-cycle counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  host byte valid.
REQ-006 SHALL have port in_data  input  8  host byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high on a clk edge.
REQ-008 SHALL have port im_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port dm_we  output  1  data-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  write address, shared by both memories.
REQ-011 SHALL have port mem_wdata  output  8  write data, shared by both memories.
REQ-012 SHALL have port cpu_reset  output  1  active-high processor reset.
REQ-013 SHALL have port cpu_hlt  input  1  processor has decoded HLT.
REQ-014 SHALL have port restart  input  1  single-cycle request to return to IDLE.
REQ-015 SHALL have port done  output  1  program halted.
REQ-016 SHALL have port err  output  1  load failed.
REQ-017 SHALL have port run_cycles  output  CNT_W  clk cycles spent in RUN.

Function
REQ-018 SHALL implement the states IDLE, ILEN, IBYTES, DLEN, DBYTES, CSUM, RUN, DONE and ERR.
REQ-019 SHALL assert in_ready only in ILEN, IBYTES, DLEN, DBYTES and CSUM.
REQ-020 SHALL move from IDLE to ILEN one cycle after reset release or after restart.
REQ-021 SHALL store the byte accepted in ILEN as the instruction count NI; NI=0 SHALL go to DLEN, otherwise to IBYTES.
REQ-022 SHALL, in IBYTES, write the k-th accepted byte (k from 0) to instruction address k; after byte NI-1 it SHALL go to DLEN.
REQ-023 SHALL treat DLEN and DBYTES identically to ILEN and IBYTES, with count ND, using dm_we; DLEN with ND=0 or the last data byte SHALL go to CSUM, or to RUN when the macro is absent.
REQ-024 SHALL register memory writes: im_we or dm_we high for exactly one cycle, the cycle after the accepting edge, with mem_addr and mem_wdata valid in that cycle; strobes SHALL be low otherwise.
REQ-025 SHALL keep cpu_reset high in every state except RUN, and drive it low in RUN.
REQ-026 SHALL increment run_cycles once per cycle in RUN, saturate at all-ones, and clear it on entry to ILEN.
REQ-027 SHALL, in RUN, go to DONE on the first edge with cpu_hlt high; cpu_hlt SHALL be ignored in all other states.
REQ-028 SHALL hold done high in DONE only, and err high in ERR only.
REQ-029 SHALL honour restart only in DONE or ERR, going to IDLE; in every other state restart SHALL be ignored.
REQ-030 SHALL ignore in_valid when in_ready is low; no byte is consumed.

Reset
REQ-031 SHALL, on reset low, immediately enter IDLE and force these outputs: in_ready=0, im_we=0, dm_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, err=0, run_cycles=0.
REQ-032 SHALL, on reset asserted mid-load or mid-run, discard all partial state; no write strobe SHALL follow the reset.

Configuration
REQ-033 SHALL, when PROG_LOADER_CHECKSUM_EN is defined, keep an 8-bit running sum (mod 256) of every byte accepted from ILEN through DBYTES, and accept one byte in CSUM.
REQ-034 SHALL, with PROG_LOADER_CHECKSUM_EN defined, go from CSUM to RUN if the CSUM byte equals the running sum, and to ERR otherwise.
REQ-035 SHALL, without PROG_LOADER_CHECKSUM_EN, omit the CSUM state and the sum logic, go directly to RUN, and never assert err.

Verification
REQ-036 SHALL cover a basic load: stream 02,11,22,01,33 (checksum off) -> im writes 11@0 and 22@1, then dm write 33@0, then cpu_reset low.
REQ-037 SHALL cover halt and cycle counting: in RUN, raise cpu_hlt after 10 cycles -> done=1, run_cycles=10, cpu_reset=1.
REQ-038 SHALL cover checksum accept and reject (macro on): stream 01,AA,00 then checksum AB -> RUN; the same stream with checksum AC -> ERR with err=1.
REQ-039 SHALL cover empty sections: stream 00,00 (checksum off) -> no write strobes, RUN entered.
REQ-040 SHALL cover reset mid-load: drive reset low during IBYTES -> all outputs at reset values; after release, a fresh load succeeds.
REQ-041 SHALL cover restart and backpressure: restart pulse in RUN -> ignored; restart in DONE -> IDLE then ILEN; in_valid toggling -> one write per handshake only.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host byte stream and shared instruction/data memory write port of prog_loader.
// The loader uses the slave modport; the host/memory side uses master.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic              dm_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, dm_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, dm_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a length-prefixed program/data image into two memories, then runs and times the CPU.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    prog_loader_if.slave     bus,
    output logic             cpu_reset,
    input  logic             cpu_hlt,
    input  logic             restart,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [3:0] {
        IDLE,
        ILEN,
        IBYTES,
        DLEN,
        DBYTES,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM,
`endif
        RUN,
        DONE,
        ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = CSUM;
`else
    localparam state_t LOAD_END = RUN;
`endif

    state_t            state;
    state_t            state_next;
    logic [7:0]        remain;
    logic [ADDR_W-1:0] idx;
    logic              load_phase;
    logic              byte_phase;
    logic              len_phase;
    logic              fire;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign load_phase = state inside {ILEN, IBYTES, DLEN, DBYTES};
    assign byte_phase = state inside {IBYTES, DBYTES};
    assign len_phase  = state inside {ILEN, DLEN};
`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.in_ready = load_phase || (state == CSUM);
`else
    assign bus.in_ready = load_phase;
`endif
    assign fire      = bus.in_valid && bus.in_ready;
    assign cpu_reset = (state != RUN);
    assign done      = (state == DONE);
    assign err       = (state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = ILEN;
            ILEN:   if (fire) state_next = (bus.in_data == 8'd0) ? DLEN : IBYTES;
            IBYTES: if (fire && remain == 8'd1) state_next = DLEN;
            DLEN:   if (fire) state_next = (bus.in_data == 8'd0) ? LOAD_END : DBYTES;
            DBYTES: if (fire && remain == 8'd1) state_next = LOAD_END;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM:   if (fire) state_next = (bus.in_data == sum) ? RUN : ERR;
`endif
            RUN:    if (cpu_hlt) state_next = DONE;
            DONE:   if (restart) state_next = IDLE;
            ERR:    if (restart) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writes are registered: strobe, address and data all appear the cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.im_we     <= 1'b0;
            bus.dm_we     <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            remain        <= '0;
            idx           <= '0;
            run_cycles    <= '0;
        end else begin
            bus.im_we <= fire && (state == IBYTES);
            bus.dm_we <= fire && (state == DBYTES);
            if (fire && byte_phase) begin
                bus.mem_addr  <= idx;
                bus.mem_wdata <= bus.in_data;
                remain        <= remain - 8'd1;
                idx           <= idx + 1'b1;
            end else if (fire && len_phase) begin
                remain <= bus.in_data;
                idx    <= '0;
            end
            if (state == IDLE)
                run_cycles <= '0;
            else if (state == RUN && run_cycles != '1)
                run_cycles <= run_cycles + 1'b1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sum <= '0;
        else if (state == IDLE)
            sum <= '0;
        else if (fire && load_phase)
            sum <= sum + bus.in_data;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: expected memory writes are queued at issue time and
// popped by an independent monitor on every write strobe.
module tb_prog_loader;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cpu_hlt = 1'b0;
    logic             restart = 1'b0;
    logic             cpu_reset;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] run_cycles;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .cpu_hlt   (cpu_hlt),
        .restart   (restart),
        .done      (done),
        .err       (err),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              dm;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] run_sum;
    logic [7:0] ibuf[16];
    logic [7:0] dbuf[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t a;
        wr_t e;
        if (bus.im_we || bus.dm_we) begin
            a = '{dm: bus.dm_we, addr: bus.mem_addr, data: bus.mem_wdata};
            check("strobe_exclusive", {31'd0, bus.im_we & bus.dm_we}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got dm=%0b addr=%0h data=%0h expected none",
                         a.dm, a.addr, a.data);
            end else begin
                e = sb.pop_front();
                check("write", 32'(a), 32'(e));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=0 expected 1");
            bus.in_valid = 1'b0;
        end else begin
            run_sum = run_sum + b;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic load(input int ni, input int nd, input int gap);
        logic [7:0] csum;
        run_sum = 8'd0;
        send(ni[7:0]);
        for (int i = 0; i < ni; i++) begin
            sb.push_back('{dm: 1'b0, addr: ADDR_W'(i), data: ibuf[i]});
            idle(int'($urandom_range(0, gap)));
            send(ibuf[i]);
        end
        idle(int'($urandom_range(0, gap)));
        send(nd[7:0]);
        for (int i = 0; i < nd; i++) begin
            sb.push_back('{dm: 1'b1, addr: ADDR_W'(i), data: dbuf[i]});
            idle(int'($urandom_range(0, gap)));
            send(dbuf[i]);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        csum = run_sum;
        send(csum);
`else
        csum = 8'd0;
`endif
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (cpu_reset && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, cpu_reset}, 32'd0);
    endtask

    task automatic halt(input string name);
        cpu_hlt = 1'b1;
        @(negedge clk);
        cpu_hlt = 1'b0;
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_im_we"}, {31'd0, bus.im_we}, 32'd0);
        check({tag, "_dm_we"}, {31'd0, bus.dm_we}, 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ilen_after_release", {31'd0, bus.in_ready}, 32'd1);

        // Basic load 02,11,22,01,33
        ibuf[0] = 8'h11; ibuf[1] = 8'h22; dbuf[0] = 8'h33;
        load(2, 1, 0);
        wait_run("basic_run");
        check("run_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // Nine RUN edges with hlt low (restart pulse and stray in_valid ignored), tenth edge halts
        for (int c = 1; c < 10; c++) begin
            restart      = (c == 3);
            bus.in_valid = (c >= 5 && c <= 7);
            bus.in_data  = 8'hFF;
            @(negedge clk);
        end
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        check("restart_ignored_run", {31'd0, cpu_reset}, 32'd0);
        check("not_done_in_run", {31'd0, done}, 32'd0);
        halt("halt_done");
        check("halt_run_cycles", 32'(run_cycles), 32'd10);
        check("halt_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        cpu_hlt = 1'b1;
        idle(3);
        cpu_hlt = 1'b0;
        check("done_held", {31'd0, done}, 32'd1);
        check("done_no_count", 32'(run_cycles), 32'd10);

        pulse_restart();
        check("idle_done_low", {31'd0, done}, 32'd0);
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("ilen_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("ilen_run_cleared", 32'(run_cycles), 32'd0);

        // Empty sections: no strobes expected
        load(0, 0, 0);
        wait_run("empty_run");
        idle(2);
        halt("empty_halt");
        pulse_restart();

        // Backpressure: gaps between bytes
        ibuf[0] = 8'hA0; ibuf[1] = 8'hA1; ibuf[2] = 8'hA2;
        dbuf[0] = 8'hB0; dbuf[1] = 8'hB1;
        load(3, 2, 3);
        wait_run("bp_run");
        idle(1);
        check("bp_all_written", sb.size(), 32'd0);
        halt("bp_halt");
        pulse_restart();

        // Reset asserted mid-IBYTES, while the second write strobe is high
        send(8'd4);
        sb.push_back('{dm: 1'b0, addr: ADDR_W'(0), data: 8'hC0});
        send(8'hC0);
        sb.push_back('{dm: 1'b0, addr: ADDR_W'(1), data: 8'hC1});
        send(8'hC1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midload");
        idle(2);
        check("midload_no_pending", sb.size(), 32'd0);
        reset = 1'b1;
        ibuf[0] = 8'hD0; dbuf[0] = 8'hE0;
        load(1, 1, 0);
        wait_run("fresh_run");
        idle(1);
        check("fresh_all_written", sb.size(), 32'd0);
        halt("fresh_halt");
        pulse_restart();

`ifdef PROG_LOADER_CHECKSUM_EN
        sb.push_back('{dm: 1'b0, addr: ADDR_W'(0), data: 8'hAA});
        send(8'h01); send(8'hAA); send(8'h00); send(8'hAB);
        wait_run("csum_ok_run");
        check("csum_ok_err", {31'd0, err}, 32'd0);
        halt("csum_ok_halt");
        pulse_restart();
        sb.push_back('{dm: 1'b0, addr: ADDR_W'(0), data: 8'hAA});
        send(8'h01); send(8'hAA); send(8'h00); send(8'hAC);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        idle(2);
        check("csum_bad_err_held", {31'd0, err}, 32'd1);
        pulse_restart();
        check("csum_restart_err", {31'd0, err}, 32'd0);
`else
        check("err_never", {31'd0, err}, 32'd0);
`endif

        idle(2);
        check("final_sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
